// File: rtl/uart_frame_scheduler_pkg.sv
// Shared UART link frame definitions: opcodes, sync pattern, snapshot layout and byte builder.
// The receiving decoder imports this same package so both ends agree on the wire format.
package uart_frame_scheduler_pkg;

    localparam int unsigned FRAME_BYTES  = 8;
    localparam logic [4:0]  SYNC_PATTERN = 5'b10101;

    typedef enum logic [2:0] {
        OP_SYNC      = 3'd0,
        OP_KEEPER_LO = 3'd1,
        OP_KEEPER_HI = 3'd2,
        OP_X_LO      = 3'd3,
        OP_X_HI      = 3'd4,
        OP_Y_LO      = 3'd5,
        OP_Y_HI      = 3'd6,
        OP_STATUS    = 3'd7
    } opcode_e;

    typedef struct packed {
        logic [9:0] keeper;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] score;
        logic       shot;
    } snapshot_t;

    // Low half always precedes high half: the receiver latches the full word on the high byte.
    function automatic logic [7:0] frame_byte(input snapshot_t s, input opcode_e op);
        logic [4:0] payload;
        case (op)
            OP_SYNC:      payload = SYNC_PATTERN;
            OP_KEEPER_LO: payload = s.keeper[4:0];
            OP_KEEPER_HI: payload = s.keeper[9:5];
            OP_X_LO:      payload = s.x[4:0];
            OP_X_HI:      payload = s.x[9:5];
            OP_Y_LO:      payload = s.y[4:0];
            OP_Y_HI:      payload = s.y[9:5];
            default:      payload = {1'b0, s.shot, s.score};
        endcase
        return {payload, op};
    endfunction

endpackage

// File: rtl/uart_frame_scheduler_if.sv
// Write port between the frame scheduler and the UART TX FIFO.
interface uart_frame_scheduler_if;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_full;

    modport master (output tx_data, output tx_wr, input tx_full);
    modport slave  (input tx_data, input tx_wr, output tx_full);
endinterface

// File: rtl/uart_frame_scheduler_timer.sv
// Frame period timer: counts 0..PERIOD-1 while enabled and pulses tick on the last count.
// Held at zero while disabled so re-enabling always restarts a full period.
module frame_period_timer #(
    parameter int unsigned PERIOD = 650_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_i,
    output logic tick_o
);
    localparam int unsigned  W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (enable_i && (cnt_q != LAST)) cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign tick_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_frame_scheduler.sv
// Transmit-side frame scheduler: snapshots local game state every period and writes it
// to the UART TX FIFO as one 8-byte frame of {payload[4:0], opcode[2:0]} bytes.
//
// state | meaning
// IDLE  | waiting for a period tick
// LOAD  | capture game state into the snapshot, issue sync byte if FIFO has room
// SEND  | issue remaining frame bytes from the snapshot, stalling while FIFO is full
module uart_frame_scheduler
    import uart_frame_scheduler_pkg::*;
#(
    parameter int unsigned FRAME_PERIOD = 650_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable_i,
    input  logic [9:0]                    keeper_pos_i,
    input  logic [9:0]                    x_shooter_i,
    input  logic [9:0]                    y_shooter_i,
    input  logic [2:0]                    my_score_i,
    input  logic                          is_shooted_i,
    uart_frame_scheduler_if.master        tx_if,
    output logic                          frame_done_o,
    output logic                          frame_overrun_o
);
    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_e;

    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

    state_e     state_q, state_d;
    snapshot_t  snap_q, snap_d;
    logic [2:0] index_q, index_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_wr_q, tx_wr_d;
    logic       frame_done_q, frame_done_d;
    logic       overrun_q, overrun_d;
    logic       tick;
    logic       frame_active;

    frame_period_timer #(.PERIOD(FRAME_PERIOD)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .enable_i (enable_i),
        .tick_o   (tick)
    );

    // The cycle that carries the last byte still belongs to the frame for overrun purposes.
    assign frame_active = (state_q != IDLE) || frame_done_q;

    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        index_d      = index_q;
        tx_data_d    = tx_data_q;
        tx_wr_d      = 1'b0;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;

        if (tick && frame_active) overrun_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (tick && !frame_active) state_d = LOAD;
            end
            LOAD: begin
                snap_d.keeper = keeper_pos_i;
                snap_d.x      = x_shooter_i;
                snap_d.y      = y_shooter_i;
                snap_d.score  = my_score_i;
                snap_d.shot   = is_shooted_i;
                index_d       = '0;
                state_d       = SEND;
                if (!tx_if.tx_full) begin
                    tx_wr_d   = 1'b1;
                    tx_data_d = frame_byte(snap_d, OP_SYNC);
                    index_d   = 3'd1;
                end
            end
            SEND: begin
                if (!tx_if.tx_full) begin
                    tx_wr_d   = 1'b1;
                    tx_data_d = frame_byte(snap_q, opcode_e'(index_q));
                    index_d   = index_q + 3'd1;
                    if (index_q == LAST_IDX) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            snap_q       <= '0;
            index_q      <= '0;
            tx_data_q    <= '0;
            tx_wr_q      <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            index_q      <= index_d;
            tx_data_q    <= tx_data_d;
            tx_wr_q      <= tx_wr_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign tx_if.tx_data   = tx_data_q;
    assign tx_if.tx_wr     = tx_wr_q;
    assign frame_done_o    = frame_done_q;
    assign frame_overrun_o = overrun_q;

endmodule
